fft_result_streamer: RTL and testbench

- Unloads the FFT result memory after the FFT controller signals completion.
- Emits results as a valid/ready stream in natural frequency order, optionally undoing the FFT's bit-reversed storage order.
- Sits between the result RAM read port (1-cycle read latency) and the downstream consumer (DMA or bus bridge).
- Owns a 2-entry output FIFO that absorbs RAM latency and backpressure while sustaining 1 beat/cycle.

---
 rtl/fft_result_streamer_if.sv | 25 ++
 rtl/fft_result_streamer.sv | 123 ++++++++++++
 tb/tb_fft_result_streamer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fft_result_streamer_if.sv
// Result-memory read port and output stream of the FFT result streamer.
// master: the streamer side; slave: memory and consumer side.
interface fft_result_streamer_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
);
  logic              mem_rd_en_o;
  logic [ADDR_W-1:0] mem_rd_addr_o;
  logic [DATA_W-1:0] mem_rd_data_i;
  logic              m_valid_o;
  logic              m_ready_i;
  logic [DATA_W-1:0] m_data_o;
  logic [ADDR_W-1:0] m_index_o;
  logic              m_last_o;

  modport master (
    output mem_rd_en_o, mem_rd_addr_o, m_valid_o, m_data_o, m_index_o, m_last_o,
    input  mem_rd_data_i, m_ready_i
  );

  modport slave (
    input  mem_rd_en_o, mem_rd_addr_o, m_valid_o, m_data_o, m_index_o, m_last_o,
    output mem_rd_data_i, m_ready_i
  );
endinterface

// File: rtl/fft_result_streamer.sv
// Unloads the FFT result RAM after completion and streams the words out in natural
// frequency order through a 2-entry FIFO that hides the 1-cycle RAM latency.
module fft_result_streamer #(
  parameter int unsigned N_POINTS    = 16,
  parameter int unsigned ADDR_W      = $clog2(N_POINTS),
  parameter int unsigned DATA_W      = 32,
  parameter bit          BIT_REVERSE = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         done_i,
  fft_result_streamer_if.master        bus,
  output logic                         busy_o,
  output logic                         unload_done_o,
  output logic                         overrun_o
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StFinish} state_e;

  localparam logic [ADDR_W-1:0] LastK = ADDR_W'(N_POINTS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_k_q, rd_k_d;
  logic [ADDR_W-1:0] ret_k_q;
  logic              inflight_q;
  logic              overrun_q;
  logic [DATA_W-1:0] fifo_data_q [2];
  logic [ADDR_W-1:0] fifo_idx_q  [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;
  logic              valid, pop, push, issue, head_last;
  logic [2:0]        occ;

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < ADDR_W; i++) r[i] = a[ADDR_W-1-i];
    return r;
  endfunction

  // FIFO status, handshake and read-issue decision
  always_comb begin
    valid     = (count_q != 2'd0);
    pop       = valid & bus.m_ready_i;
    push      = inflight_q;
    head_last = (fifo_idx_q[rd_ptr_q] == LastK);
    // Entries buffered plus in flight after this cycle's pop; issuing keeps it <= 2.
    occ       = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    issue     = (state_q == StFetch) && (occ < 3'd2);
  end

  // Next-state logic and read index advance
  always_comb begin
    state_d = state_q;
    rd_k_d  = rd_k_q;
    unique case (state_q)
      StIdle: begin
        if (done_i) begin
          state_d = StFetch;
          rd_k_d  = '0;
        end
      end
      StFetch: begin
        if (issue) begin
          if (rd_k_q == LastK) state_d = StDrain;
          else                 rd_k_d  = rd_k_q + 1'b1;
        end
      end
      StDrain: begin
        // Final beat leaves the only occupied slot and nothing else is pending.
        if (pop && head_last && (count_q == 2'd1) && !inflight_q) state_d = StFinish;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output drive; stream fields are zeroed whenever no beat is presented
  always_comb begin
    bus.mem_rd_en_o   = issue;
    bus.mem_rd_addr_o = '0;
    if (issue) bus.mem_rd_addr_o = BIT_REVERSE ? bitrev(rd_k_q) : rd_k_q;
    bus.m_valid_o     = valid;
    bus.m_data_o      = valid ? fifo_data_q[rd_ptr_q] : '0;
    bus.m_index_o     = valid ? fifo_idx_q[rd_ptr_q] : '0;
    bus.m_last_o      = valid & head_last;
    busy_o            = (state_q == StFetch) || (state_q == StDrain);
    unload_done_o     = (state_q == StFinish);
    overrun_o         = overrun_q;
  end

  // State, read tracking and FIFO storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      rd_k_q     <= '0;
      ret_k_q    <= '0;
      inflight_q <= 1'b0;
      overrun_q  <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_idx_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      rd_k_q     <= rd_k_d;
      inflight_q <= issue;
      overrun_q  <= done_i && (state_q != StIdle);
      if (issue) ret_k_q <= rd_k_q;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= bus.mem_rd_data_i;
        fifo_idx_q[wr_ptr_q]  <= ret_k_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_fft_result_streamer.sv
// Bench for fft_result_streamer: two instances (bit-reversed and identity order) share
// done/ready/reset; expected beats are queued at each done and popped on every handshake.
module tb_fft_result_streamer;

  localparam int unsigned N = 8;
  localparam int unsigned AW = 3;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic done_i;
  logic ready;
  logic busy_br, ud_br, ovr_br, busy_id, ud_id, ovr_id;

  int checks = 0;
  int errors = 0;
  int issued_br, issued_id, beats_br, beats_id, ovr_cnt, ud_cnt;
  int q_br[$];
  int q_id[$];
  bit stall_prev;
  logic [31:0] prev_data;
  logic [AW-1:0] prev_idx;

  always #5 clk_i = ~clk_i;

  fft_result_streamer_if #(.ADDR_W(AW), .DATA_W(32)) if_br ();
  fft_result_streamer_if #(.ADDR_W(AW), .DATA_W(32)) if_id ();

  assign if_br.m_ready_i = ready;
  assign if_id.m_ready_i = ready;

  fft_result_streamer #(.N_POINTS(N), .ADDR_W(AW), .DATA_W(32), .BIT_REVERSE(1'b1)) dut_br (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .done_i        (done_i),
    .bus           (if_br),
    .busy_o        (busy_br),
    .unload_done_o (ud_br),
    .overrun_o     (ovr_br)
  );

  fft_result_streamer #(.N_POINTS(N), .ADDR_W(AW), .DATA_W(32), .BIT_REVERSE(1'b0)) dut_id (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .done_i        (done_i),
    .bus           (if_id),
    .busy_o        (busy_id),
    .unload_done_o (ud_id),
    .overrun_o     (ovr_id)
  );

  // Result memory models: mem[a] = a + 100, one-cycle read latency
  always @(posedge clk_i) begin
    if (if_br.mem_rd_en_o) if_br.mem_rd_data_i <= 32'(if_br.mem_rd_addr_o) + 32'd100;
    if (if_id.mem_rd_en_o) if_id.mem_rd_data_i <= 32'(if_id.mem_rd_addr_o) + 32'd100;
  end

  function automatic int br3(input int k);
    logic [2:0] a;
    a = 3'(k);
    return int'({a[0], a[1], a[2]});
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_valid"}, if_br.m_valid_o, 0);
    check({pfx, "_last"}, if_br.m_last_o, 0);
    check({pfx, "_data"}, if_br.m_data_o, 0);
    check({pfx, "_index"}, if_br.m_index_o, 0);
    check({pfx, "_rd_en"}, if_br.mem_rd_en_o, 0);
    check({pfx, "_rd_addr"}, if_br.mem_rd_addr_o, 0);
    check({pfx, "_busy"}, busy_br, 0);
    check({pfx, "_unload_done"}, ud_br, 0);
    check({pfx, "_overrun"}, ovr_br, 0);
  endtask

  // Monitor: address sequence, scoreboard pops, stall stability, occupancy bound
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (if_br.mem_rd_en_o) begin
        check("addr_br", if_br.mem_rd_addr_o, br3(issued_br));
        issued_br++;
      end else check("addr_br_idle", if_br.mem_rd_addr_o, 0);
      if (if_id.mem_rd_en_o) begin
        check("addr_id", if_id.mem_rd_addr_o, issued_id);
        issued_id++;
      end else check("addr_id_idle", if_id.mem_rd_addr_o, 0);

      if (stall_prev) begin
        check("stall_valid", if_br.m_valid_o, 1);
        check("stall_data", if_br.m_data_o, prev_data);
        check("stall_index", if_br.m_index_o, prev_idx);
      end
      stall_prev = if_br.m_valid_o && !ready;
      prev_data  = if_br.m_data_o;
      prev_idx   = if_br.m_index_o;

      if (if_br.m_valid_o && ready) begin
        check("beat_expected_br", q_br.size() != 0, 1);
        if (q_br.size() != 0) check("data_br", if_br.m_data_o, q_br.pop_front());
        check("index_br", if_br.m_index_o, beats_br % N);
        check("last_br", if_br.m_last_o, beats_br == N - 1);
        beats_br++;
      end
      if (if_id.m_valid_o && ready) begin
        check("beat_expected_id", q_id.size() != 0, 1);
        if (q_id.size() != 0) check("data_id", if_id.m_data_o, q_id.pop_front());
        check("index_id", if_id.m_index_o, beats_id % N);
        check("last_id", if_id.m_last_o, beats_id == N - 1);
        beats_id++;
      end
      if (if_br.mem_rd_en_o) check("outstanding_le2", (issued_br - beats_br) <= 2, 1);
      if (ovr_br) ovr_cnt++;
      if (ud_br) ud_cnt++;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // mode 0: ready high; 1: ready 1,0,0,1 pattern; 2: ready low 20 cycles; 3: reset after k=3
  task automatic run_unload(input int mode, input int ovr_at, output int first_v,
                            output int ud_at);
    first_v = -1;
    ud_at   = -1;
    @(posedge clk_i); #1;
    issued_br = 0; issued_id = 0; beats_br = 0; beats_id = 0; ovr_cnt = 0; ud_cnt = 0;
    for (int k = 0; k < N; k++) begin
      q_br.push_back(br3(k) + 100);
      q_id.push_back(k + 100);
    end
    done_i = 1'b1;
    ready  = (mode != 2);
    for (int c = 1; c < 200; c++) begin
      @(posedge clk_i); #1;
      done_i = (c == ovr_at);
      unique case (mode)
        1:       ready = ((c % 4) == 0) || ((c % 4) == 3);
        2:       ready = (c > 20);
        default: ready = 1'b1;
      endcase
      @(negedge clk_i); #1;
      if (first_v < 0 && if_br.m_valid_o) first_v = c;
      if (mode == 2 && c == 20) begin
        check("stall_reads_issued", issued_br, 2);
        check("stall_busy", busy_br, 1);
        check("stall_head_data", if_br.m_data_o, 100);
        check("stall_valid_held", if_br.m_valid_o, 1);
      end
      if (mode == 3 && beats_br == 4) begin
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        #1;
        check_all_zero("midrst");
        q_br.delete();
        q_id.delete();
        return;
      end
      if (ud_br && ud_at < 0) ud_at = c;
      if (ud_at >= 0 && c == ud_at + 1) begin
        check("idle_after_finish", busy_br, 0);
        break;
      end
    end
    check("unload_done_seen", ud_at >= 0, 1);
    check("beats_br", beats_br, N);
    check("beats_id", beats_id, N);
    check("unload_done_count", ud_cnt, 1);
    check("sb_empty_br", q_br.size(), 0);
    check("sb_empty_id", q_id.size(), 0);
    check("overrun_count", ovr_cnt, (ovr_at > 0) ? 1 : 0);
    check("first_valid_cycle", first_v, 3);
  endtask

  initial begin
    int fv, ud;
    rst_ni = 1'b0;
    done_i = 1'b0;
    ready  = 1'b0;
    stall_prev = 1'b0;
    repeat (2) @(negedge clk_i);
    check_all_zero("reset");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);

    // Streaming with ready held high, both orderings
    run_unload(0, 0, fv, ud);
    check("unload_done_cycle", ud, N + 3);

    // Backpressure pattern
    run_unload(1, 0, fv, ud);

    // done_i mid-unload, then done_i on the FINISH cycle
    run_unload(0, 5, fv, ud);
    check("ovr_mid_done_cycle", ud, N + 3);
    run_unload(0, N + 3, fv, ud);

    // Reset after beat k=3, restart with full latency
    run_unload(3, 0, fv, ud);
    repeat (2) @(posedge clk_i); #1;
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i); #1;
      check("post_rst_no_beat", if_br.m_valid_o, 0);
    end
    run_unload(0, 0, fv, ud);
    check("restart_done_cycle", ud, N + 3);

    // Consumer stalled for 20 cycles after done
    run_unload(2, 0, fv, ud);

    repeat (2) @(posedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
